unary_window_decoder: RTL and testbench

Unary-to-binary decoder for the stochastic-computing datapath: accepts a single-bit unary bitstream (e.g. the output of the mux-based scaled adder) and counts its ones over a fixed window of 2^BITWIDTH valid bits. Each window's result goes out as a binary word on a valid/ready handshake, optionally shifted left to undo an upstream 1/2^LOGSCALE scaling. Sits at the back end of a unary pipeline, returning results to the binary domain.

---
 rtl/unary_window_decoder_pkg.sv | 17 +
 rtl/unary_window_decoder_if.sv | 30 +++
 rtl/unary_window_decoder_win_cnt.sv | 43 ++++
 rtl/unary_window_decoder.sv | 84 ++++++++
 tb/tb_unary_window_decoder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/unary_window_decoder_pkg.sv
// Shared types and sizing helpers for the unary-to-binary window decoder.
package unary_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic int win_len(input int bw);
    return 32'sd1 << bw;
  endfunction

  function automatic int out_width(input int bw, input int ls);
    return bw + 32'sd1 + ls;
  endfunction

endpackage

// File: rtl/unary_window_decoder_if.sv
// Control, unary stream and result handshake bundle of the window decoder.
interface unary_window_decoder_if #(
  parameter int BITWIDTH = 8,
  parameter int LOGSCALE = 0
);
  import unary_pkg::*;

  localparam int OW = out_width(BITWIDTH, LOGSCALE);

  logic          start;
  logic          cont;
  logic          in_valid;
  logic          in_bit;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          overrun;

  modport master (
    output start, cont, in_valid, in_bit, out_ready,
    input  out_data, out_valid, busy, overrun
  );

  modport slave (
    input  start, cont, in_valid, in_bit, out_ready,
    output out_data, out_valid, busy, overrun
  );

endinterface

// File: rtl/unary_window_decoder_win_cnt.sv
// Window position counter and ones accumulator; flags the last bit of a window
// and presents the window sum including that bit.
module unary_win_cnt
  import unary_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              in_bit,
  output logic              last,
  output logic [BITWIDTH:0] sum
);

  localparam logic [BITWIDTH-1:0] LAST_IDX = BITWIDTH'(win_len(BITWIDTH) - 1);
  localparam logic [BITWIDTH-1:0] ONE_CNT  = {{(BITWIDTH-1){1'b0}}, 1'b1};

  logic [BITWIDTH-1:0] win_cnt_r;
  logic [BITWIDTH:0]   ones_r;

  assign last = en & (win_cnt_r == LAST_IDX);
  assign sum  = ones_r + {{BITWIDTH{1'b0}}, in_bit};

  // Window position and running ones count; both restart on clear or window end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_r <= {BITWIDTH{1'b0}};
      ones_r    <= {(BITWIDTH+1){1'b0}};
    end else if (clr | last) begin
      win_cnt_r <= {BITWIDTH{1'b0}};
      ones_r    <= {(BITWIDTH+1){1'b0}};
    end else if (en) begin
      win_cnt_r <= win_cnt_r + ONE_CNT;
      ones_r    <= sum;
    end else begin
      win_cnt_r <= win_cnt_r;
      ones_r    <= ones_r;
    end
  end

endmodule

// File: rtl/unary_window_decoder.sv
// Counts ones of a unary bitstream over 2^BITWIDTH valid bits and returns each
// window's (scaled) count on a valid/ready result register.
module unary_window_decoder
  import unary_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int LOGSCALE = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  unary_window_decoder_if.slave bus
);

  localparam int OW = out_width(BITWIDTH, LOGSCALE);

  state_t            state_r;
  logic [OW-1:0]     out_data_r;
  logic              out_valid_r;
  logic              overrun_r;
  logic              clr_s;
  logic              en_s;
  logic              last_s;
  logic [BITWIDTH:0] sum_s;

  assign clr_s = (state_r == IDLE) & bus.start;
  assign en_s  = (state_r == ACCUM) & bus.in_valid;

  unary_win_cnt #(.BITWIDTH(BITWIDTH)) u_win_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_s),
    .en     (en_s),
    .in_bit (bus.in_bit),
    .last   (last_s),
    .sum    (sum_s)
  );

  // Window FSM plus result/handshake register; a new result wins over a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_data_r  <= {OW{1'b0}};
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r   <= ACCUM;
            overrun_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM: begin
          if (last_s) begin
            state_r <= bus.cont ? ACCUM : IDLE;
          end else begin
            state_r <= ACCUM;
          end
        end
        default: state_r <= IDLE;
      endcase

      if (last_s) begin
        out_data_r  <= OW'(sum_s) << LOGSCALE;
        out_valid_r <= 1'b1;
        if (out_valid_r & ~bus.out_ready) begin
          overrun_r <= 1'b1;
        end
      end else if (out_valid_r & bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.overrun   = overrun_r;
  assign bus.busy      = (state_r == ACCUM);

endmodule

// File: tb/tb_unary_window_decoder.sv
// Directed bench for unary_window_decoder (BITWIDTH=4) with a window-level
// reference model; a LOGSCALE=2 copy shares the stimulus.
module tb_unary_window_decoder;
  import unary_pkg::*;

  localparam int BW  = 4;
  localparam int WIN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  unary_window_decoder_if #(.BITWIDTH(BW), .LOGSCALE(0)) if0 ();
  unary_window_decoder_if #(.BITWIDTH(BW), .LOGSCALE(2)) if2 ();

  assign if2.start     = if0.start;
  assign if2.cont      = if0.cont;
  assign if2.in_valid  = if0.in_valid;
  assign if2.in_bit    = if0.in_bit;
  assign if2.out_ready = if0.out_ready;

  unary_window_decoder #(.BITWIDTH(BW), .LOGSCALE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  unary_window_decoder #(.BITWIDTH(BW), .LOGSCALE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference: a window is 16 accepted bits; its ones count becomes the result.
  bit m_run = 1'b0;
  int m_seen = 0, m_ones = 0, m_data = 0;
  bit m_valid = 1'b0, m_ovr = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit run_v, valid_v, ovr_v;
    int seen_v, ones_v, data_v;
    if (!rst_n) begin
      m_run <= 1'b0; m_seen <= 0; m_ones <= 0;
      m_valid <= 1'b0; m_data <= 0; m_ovr <= 1'b0;
    end else begin
      run_v = m_run; seen_v = m_seen; ones_v = m_ones;
      valid_v = m_valid; data_v = m_data; ovr_v = m_ovr;
      if (m_valid && if0.out_ready) valid_v = 1'b0;
      if (!m_run) begin
        if (if0.start) begin
          run_v = 1'b1; seen_v = 0; ones_v = 0; ovr_v = 1'b0;
        end
      end else if (if0.in_valid) begin
        seen_v = seen_v + 1;
        ones_v = ones_v + int'(if0.in_bit);
        if (seen_v == WIN) begin
          if (m_valid && !if0.out_ready) ovr_v = 1'b1;
          data_v = ones_v; valid_v = 1'b1;
          seen_v = 0; ones_v = 0; run_v = if0.cont;
        end
      end
      m_run <= run_v; m_seen <= seen_v; m_ones <= ones_v;
      m_valid <= valid_v; m_data <= data_v; m_ovr <= ovr_v;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("out_valid", int'(if0.out_valid), int'(m_valid));
    chk("out_data",  int'(if0.out_data),  m_data);
    chk("busy",      int'(if0.busy),      int'(m_run));
    chk("overrun",   int'(if0.overrun),   int'(m_ovr));
    chk("ls2_out_data",  int'(if2.out_data),  m_data * 4);
    chk("ls2_out_valid", int'(if2.out_valid), int'(m_valid));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
  endtask

  task automatic run_window(input logic [15:0] pat, input bit gap, output int cycles);
    cycles = 0;
    for (int i = 0; i < WIN; i++) begin
      if0.in_valid = 1'b1;
      if0.in_bit   = pat[i];
      tick();
      cycles++;
      if (gap) begin
        if0.in_valid = 1'b0;
        if0.in_bit   = 1'b1;
        tick();
        cycles++;
      end
    end
    if0.in_valid = 1'b0;
    if0.in_bit   = 1'b0;
  endtask

  initial begin
    int cyc;
    if0.start = 1'b0; if0.cont = 1'b0; if0.in_valid = 1'b0;
    if0.in_bit = 1'b0; if0.out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", int'(if0.out_valid), 0);
    chk("rst_out_data",  int'(if0.out_data),  0);
    chk("rst_busy",      int'(if0.busy),      0);
    chk("rst_overrun",   int'(if0.overrun),   0);

    // Alternating pattern, single window
    if0.out_ready = 1'b1;
    do_start();
    chk("busy_after_start", int'(if0.busy), 1);
    run_window(16'h5555, 1'b0, cyc);
    chk("alt_data",  int'(if0.out_data),  8);
    chk("alt_valid", int'(if0.out_valid), 1);
    chk("alt_busy",  int'(if0.busy),      0);
    tick();
    chk("alt_valid_drop", int'(if0.out_valid), 0);

    do_start();
    run_window(16'hFFFF, 1'b0, cyc);
    chk("ones_data", int'(if0.out_data), 16);
    tick();
    do_start();
    run_window(16'h0000, 1'b0, cyc);
    chk("zeros_data",  int'(if0.out_data),  0);
    chk("zeros_valid", int'(if0.out_valid), 1);
    tick();

    // Half-rate in_valid: the window spans 32 cycles
    do_start();
    run_window(16'hFFFF, 1'b1, cyc);
    chk("gap_cycles", cyc, 32);
    chk("gap_data",   int'(if0.out_data), 16);
    tick();

    // Continuous mode, back-to-back windows
    if0.cont = 1'b1;
    do_start();
    run_window(16'h000F, 1'b0, cyc);
    chk("cont_w1", int'(if0.out_data), 4);
    run_window(16'h01FF, 1'b0, cyc);
    chk("cont_w2", int'(if0.out_data), 9);
    if0.cont = 1'b0;
    run_window(16'hFFFF, 1'b0, cyc);
    chk("cont_w3",   int'(if0.out_data), 16);
    chk("cont_idle", int'(if0.busy),     0);
    tick();

    // Unconsumed result overwritten
    if0.out_ready = 1'b0;
    if0.cont = 1'b1;
    do_start();
    run_window(16'h0007, 1'b0, cyc);
    chk("ovr_w1_data", int'(if0.out_data), 3);
    chk("ovr_w1_flag", int'(if0.overrun),  0);
    if0.cont = 1'b0;
    run_window(16'h001F, 1'b0, cyc);
    chk("ovr_w2_data", int'(if0.out_data), 5);
    chk("ovr_w2_flag", int'(if0.overrun),  1);
    chk("ls2_data",    int'(if2.out_data), 20);
    repeat (3) tick();
    chk("ovr_sticky", int'(if0.overrun),   1);
    chk("ovr_held",   int'(if0.out_valid), 1);
    if0.out_ready = 1'b1;
    tick();
    chk("ovr_consumed", int'(if0.out_valid), 0);
    chk("ovr_kept",     int'(if0.overrun),   1);
    do_start();
    chk("ovr_cleared", int'(if0.overrun), 0);
    run_window(16'h0000, 1'b0, cyc);
    tick();

    // Asynchronous reset mid-window with a pending result
    if0.out_ready = 1'b0;
    if0.cont = 1'b1;
    do_start();
    run_window(16'h00FF, 1'b0, cyc);
    for (int i = 0; i < 5; i++) begin
      if0.in_valid = 1'b1;
      if0.in_bit = 1'b1;
      tick();
    end
    if0.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",   int'(if0.out_valid), 0);
    chk("arst_data",    int'(if0.out_data),  0);
    chk("arst_busy",    int'(if0.busy),      0);
    chk("arst_overrun", int'(if0.overrun),   0);
    tick();
    rst_n = 1'b1;
    if0.out_ready = 1'b1;
    if0.cont = 1'b0;
    tick();
    do_start();
    run_window(16'h0707, 1'b0, cyc);
    chk("fresh_data",  int'(if0.out_data),  6);
    chk("fresh_valid", int'(if0.out_valid), 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
